// File: rtl/async_receiver_pkg.sv
// async_receiver_pkg
// Shared definitions for the asynchronous serial receiver: the receive
// state encoding, the frame geometry and the phase-accumulator scaling
// constants used by baud_tick_gen.
package async_receiver_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int DATA_BITS = 8;
    localparam int IDLE_BITS = 10;

    // The accumulator is ACC_WIDTH bits plus a carry bit.
    // SHIFT_LIMITER pre-scales the increment so the 64-bit constant
    // arithmetic keeps enough precision without overflowing.
    localparam int ACC_WIDTH     = 16;
    localparam int SHIFT_LIMITER = 4;

endpackage

// File: rtl/async_receiver_baud_tick_gen.sv
// baud_tick_gen
// Fractional phase accumulator producing one-clock sample ticks at
// Baud*Oversampling Hz from a ClkFrequency Hz clock.
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous active-high reset, clears the accumulator
//   enable - accumulator runs while high, held at zero while low
//   tick   - one-clock pulse each time the accumulator carries out
module baud_tick_gen
    import async_receiver_pkg::*;
#(
    parameter int ClkFrequency = 50000000,
    parameter int Baud         = 115200,
    parameter int Oversampling = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    // Rounded increment: the (ClkFrequency >> 5) term adds half of the
    // divisor before dividing.
    localparam logic [63:0] INC_WIDE =
        (((64'(Baud) * 64'(Oversampling)) << (ACC_WIDTH - SHIFT_LIMITER))
         + (64'(ClkFrequency) >> (SHIFT_LIMITER + 1)))
        / (64'(ClkFrequency) >> SHIFT_LIMITER);
    localparam logic [ACC_WIDTH:0] INC = INC_WIDE[ACC_WIDTH:0];

    logic [ACC_WIDTH:0] acc;

    // The carry bit is dropped before each add, so it is high for
    // exactly the one cycle following an overflow.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            acc <= '0;
        end else begin
            acc <= {1'b0, acc[ACC_WIDTH-1:0]} + INC;
        end
    end

    assign tick = acc[ACC_WIDTH];

endmodule

// File: rtl/async_receiver.sv
// async_receiver
// 8N1 asynchronous serial receiver with oversampled mid-bit sampling,
// start-bit glitch rejection and line-idle / end-of-packet detection.
// Optional feature macro: RX_FRAME_ERR_EN adds a stop-bit check and the
// RxD_frame_err output.
// Ports:
//   clk             - system clock, rising edge
//   rst             - synchronous active-high reset
//   RxD             - asynchronous serial input, idle high
//   RxD_data        - last received byte, held until the next valid frame
//   RxD_data_ready  - one-clock pulse when RxD_data is updated
//   RxD_idle        - line has been high for at least IDLE_BITS bit times
//   RxD_endofpacket - one-clock pulse when RxD_idle rises
//   RxD_frame_err   - (RX_FRAME_ERR_EN only) one-clock pulse on a low stop bit
module async_receiver
    import async_receiver_pkg::*;
#(
    parameter int ClkFrequency = 50000000,
    parameter int Baud         = 115200,
    parameter int Oversampling = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       RxD_idle,
    output logic       RxD_endofpacket
`ifdef RX_FRAME_ERR_EN
    ,
    output logic       RxD_frame_err
`endif
);

    if (Oversampling != 8 && Oversampling != 16) begin : g_bad_oversampling
        $error("async_receiver: Oversampling must be 8 or 16");
    end

    localparam logic [4:0] HALF_LAST = 5'(Oversampling / 2 - 1);
    localparam logic [4:0] FULL_LAST = 5'(Oversampling - 1);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [7:0] IDLE_LAST = 8'(Oversampling * IDLE_BITS - 1);

    rx_state_t  state;
    rx_state_t  state_next;
    logic       rxd_meta;
    logic       rxd_sync;
    logic       tick;
    logic       idle_tick;
    logic [4:0] tick_count;
    logic [2:0] bit_count;
    logic [7:0] shift_reg;
    logic [7:0] idle_count;
    logic       sample_point;
    logic       shift_en;
    logic       deliver;
`ifdef RX_FRAME_ERR_EN
    logic       err_hold;
    logic       frame_err_now;
`endif

    // Synchronizer resets to the idle level so reset release never looks
    // like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= RxD;
            rxd_sync <= rxd_meta;
        end
    end

    // Frame timing runs only while a frame is in progress, so every frame
    // starts its sample grid from a zero accumulator phase.
    baud_tick_gen #(
        .ClkFrequency (ClkFrequency),
        .Baud         (Baud),
        .Oversampling (Oversampling)
    ) u_frame_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (state != IDLE),
        .tick   (tick)
    );

    // A second generator times the idle gap; it restarts on every low.
    baud_tick_gen #(
        .ClkFrequency (ClkFrequency),
        .Baud         (Baud),
        .Oversampling (Oversampling)
    ) u_idle_tick (
        .clk    (clk),
        .rst    (rst),
        .enable ((state == IDLE) && rxd_sync),
        .tick   (idle_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!rxd_sync) begin
                    state_next = START;
                end
            end
            START: begin
                if (sample_point) begin
                    state_next = rxd_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample_point && (bit_count == LAST_BIT)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
`ifdef RX_FRAME_ERR_EN
                // After a bad stop bit, wait for the line to recover so the
                // low level is not mistaken for the next start bit.
                if (err_hold) begin
                    if (rxd_sync) begin
                        state_next = IDLE;
                    end
                end else if (sample_point && rxd_sync) begin
                    state_next = IDLE;
                end
`else
                // Leaving at mid-stop leaves half a bit to catch a
                // back-to-back start edge.
                if (sample_point) begin
                    state_next = IDLE;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // START samples half a bit in; every later sample is a full bit
    // after the previous one, landing on bit centres.
    always_comb begin
        sample_point = tick && (tick_count == ((state == START) ? HALF_LAST : FULL_LAST));
        shift_en     = (state == DATA) && sample_point;
`ifdef RX_FRAME_ERR_EN
        deliver       = (state == STOP) && !err_hold && sample_point && rxd_sync;
        frame_err_now = (state == STOP) && !err_hold && sample_point && !rxd_sync;
`else
        deliver       = (state == STOP) && sample_point;
`endif
    end

    // Tick counter restarts on every state change so each state measures
    // its own sample distance.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_count     <= '0;
            bit_count      <= '0;
            shift_reg      <= '0;
            RxD_data       <= '0;
            RxD_data_ready <= 1'b0;
        end else begin
            if (state == IDLE || state_next != state) begin
                tick_count <= '0;
            end else if (tick) begin
                tick_count <= (tick_count == FULL_LAST) ? 5'd0 : tick_count + 5'd1;
            end

            if (state != DATA) begin
                bit_count <= '0;
            end else if (shift_en) begin
                bit_count <= bit_count + 3'd1;
            end

            if (shift_en) begin
                shift_reg <= {rxd_sync, shift_reg[7:1]};
            end

            if (deliver) begin
                RxD_data <= shift_reg;
            end
            RxD_data_ready <= deliver;
        end
    end

`ifdef RX_FRAME_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_hold      <= 1'b0;
            RxD_frame_err <= 1'b0;
        end else begin
            if (state != STOP) begin
                err_hold <= 1'b0;
            end else if (frame_err_now) begin
                err_hold <= 1'b1;
            end
            RxD_frame_err <= frame_err_now;
        end
    end
`endif

    // Idle detection: IDLE_BITS bit times of high line while in IDLE.
    // RxD_endofpacket is raised in the same cycle RxD_idle first rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_count      <= '0;
            RxD_idle        <= 1'b0;
            RxD_endofpacket <= 1'b0;
        end else if (!((state == IDLE) && rxd_sync)) begin
            idle_count      <= '0;
            RxD_idle        <= 1'b0;
            RxD_endofpacket <= 1'b0;
        end else begin
            RxD_endofpacket <= 1'b0;
            if (idle_tick && !RxD_idle) begin
                if (idle_count == IDLE_LAST) begin
                    RxD_idle        <= 1'b1;
                    RxD_endofpacket <= 1'b1;
                end else begin
                    idle_count <= idle_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_async_receiver.sv
// tb_async_receiver
// Scoreboard bench for async_receiver at 50 MHz / 115200 baud / x16.
// Expected bytes are queued as frames are driven and compared when
// RxD_data_ready pulses.
module tb_async_receiver;

    localparam int CLK_HZ   = 50000000;
    localparam int BAUD     = 115200;
    localparam int OS       = 16;
    localparam int BIT_CLKS = 434;

    logic       clk = 1'b0;
    logic       rst;
    logic       RxD;
    logic [7:0] RxD_data;
    logic       RxD_data_ready;
    logic       RxD_idle;
    logic       RxD_endofpacket;
`ifdef RX_FRAME_ERR_EN
    logic       RxD_frame_err;
`endif

    always #10 clk = ~clk;

    async_receiver #(
        .ClkFrequency (CLK_HZ),
        .Baud         (BAUD),
        .Oversampling (OS)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .RxD             (RxD),
        .RxD_data        (RxD_data),
        .RxD_data_ready  (RxD_data_ready),
        .RxD_idle        (RxD_idle),
        .RxD_endofpacket (RxD_endofpacket)
`ifdef RX_FRAME_ERR_EN
        ,
        .RxD_frame_err   (RxD_frame_err)
`endif
    );

    int         n_compared   = 0;
    int         n_mismatched = 0;
    logic [7:0] expected_q[$];
    int         ready_count  = 0;
    int         eop_count    = 0;
    int         err_count    = 0;
    logic       prev_ready   = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, observed, expected);
        end
    endtask

    // Output monitor: pops the scoreboard on each data-ready pulse.
    always @(negedge clk) begin
        if (RxD_data_ready) begin
            ready_count++;
            checkOutput("ready_width", 32'(prev_ready), 32'd0);
            if (expected_q.size() == 0) begin
                checkOutput("ready_without_frame", 32'(expected_q.size()), 32'd1);
            end else begin
                checkOutput("rx_byte", 32'(RxD_data), 32'(expected_q.pop_front()));
            end
        end
        prev_ready = RxD_data_ready;
        if (RxD_endofpacket) eop_count++;
`ifdef RX_FRAME_ERR_EN
        if (RxD_frame_err) err_count++;
`endif
    end

    task automatic driveBit(input logic level, input int clks);
        RxD = level;
        repeat (clks) @(negedge clk);
    endtask

    // Drives one 8N1 frame; a low stop bit is held past mid-bit only,
    // then the line returns high.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_level,
                                 input bit expect_byte);
        if (expect_byte) expected_q.push_back(data);
        driveBit(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) driveBit(data[i], BIT_CLKS);
        if (stop_level) begin
            driveBit(1'b1, BIT_CLKS);
        end else begin
            driveBit(1'b0, 260);
            driveBit(1'b1, BIT_CLKS - 260);
        end
    endtask

    initial begin
        #(1800000);
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int snap;
        rst = 1'b1;
        RxD = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_data", 32'(RxD_data), 32'h00);
        checkOutput("reset_ready", 32'(RxD_data_ready), 32'd0);
        checkOutput("reset_idle", 32'(RxD_idle), 32'd0);
        checkOutput("reset_eop", 32'(RxD_endofpacket), 32'd0);
        repeat (11 * BIT_CLKS) @(negedge clk);
        checkOutput("idle_after_reset", 32'(RxD_idle), 32'd1);

        $display("[TB] frame 0x55");
        applyStimulus(8'h55, 1'b1, 1'b1);
        checkOutput("pending_55", 32'(expected_q.size()), 32'd0);
        checkOutput("data_55", 32'(RxD_data), 32'h55);
        driveBit(1'b1, 2 * BIT_CLKS);

        $display("[TB] start glitch");
        snap = ready_count;
        driveBit(1'b0, 100);
        driveBit(1'b1, 2 * BIT_CLKS);
        checkOutput("glitch_ready", 32'(ready_count - snap), 32'd0);
        checkOutput("glitch_data_hold", 32'(RxD_data), 32'h55);

        $display("[TB] back-to-back 0xA5 0x3C");
        snap = ready_count;
        applyStimulus(8'hA5, 1'b1, 1'b1);
        applyStimulus(8'h3C, 1'b1, 1'b1);
        checkOutput("pending_b2b", 32'(expected_q.size()), 32'd0);
        checkOutput("b2b_ready_count", 32'(ready_count - snap), 32'd2);
        driveBit(1'b1, 2 * BIT_CLKS);

        $display("[TB] 0x81 with low stop bit");
        snap = err_count;
`ifdef RX_FRAME_ERR_EN
        applyStimulus(8'h81, 1'b0, 1'b0);
        checkOutput("frame_err_count", 32'(err_count - snap), 32'd1);
        checkOutput("frame_err_data_hold", 32'(RxD_data), 32'h3C);
`else
        applyStimulus(8'h81, 1'b0, 1'b1);
        checkOutput("no_stop_check_data", 32'(RxD_data), 32'h81);
`endif
        checkOutput("pending_81", 32'(expected_q.size()), 32'd0);
        driveBit(1'b1, 2 * BIT_CLKS);

        $display("[TB] reset during bit 3 of 0xF0");
        driveBit(1'b0, BIT_CLKS);
        driveBit(1'b0, BIT_CLKS);
        driveBit(1'b0, BIT_CLKS);
        driveBit(1'b0, BIT_CLKS);
        driveBit(1'b0, 200);
        rst = 1'b1;
        RxD = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midreset_data", 32'(RxD_data), 32'h00);
        checkOutput("midreset_ready", 32'(RxD_data_ready), 32'd0);
        checkOutput("midreset_idle", 32'(RxD_idle), 32'd0);
        checkOutput("midreset_eop", 32'(RxD_endofpacket), 32'd0);
        driveBit(1'b1, 2 * BIT_CLKS);
        applyStimulus(8'h0F, 1'b1, 1'b1);
        checkOutput("pending_0f", 32'(expected_q.size()), 32'd0);
        checkOutput("data_0f", 32'(RxD_data), 32'h0F);

        $display("[TB] idle and end of packet");
        checkOutput("idle_busy", 32'(RxD_idle), 32'd0);
        snap = eop_count;
        driveBit(1'b1, 11 * BIT_CLKS);
        checkOutput("idle_rise", 32'(RxD_idle), 32'd1);
        checkOutput("eop_single", 32'(eop_count - snap), 32'd1);
        fork
            applyStimulus(8'h5A, 1'b1, 1'b1);
            begin
                repeat (20) @(negedge clk);
                checkOutput("idle_fall", 32'(RxD_idle), 32'd0);
            end
        join
        checkOutput("pending_5a", 32'(expected_q.size()), 32'd0);
        driveBit(1'b1, BIT_CLKS);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/async_receiver.md
ASYNC_RECEIVER -- requirements
Module: async_receiver

Interface
REQ-001 SHALL have parameter ClkFrequency, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter Baud, default 115200, serial bit rate.
REQ-003 SHALL have parameter Oversampling, default 16, sample ticks per bit; legal values 8 and 16 only.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port RxD  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port RxD_data  output  8  last received byte.
REQ-008 SHALL have port RxD_data_ready  output  1  one-clk pulse, RxD_data valid.
REQ-009 SHALL have port RxD_idle  output  1  line high for at least 10 bit times.
REQ-010 SHALL have port RxD_endofpacket  output  1  one-clk pulse on RxD_idle rising.

Function
REQ-011 SHALL pass RxD through a 2-flop synchronizer before any use.
REQ-012 SHALL generate sample tick by phase accumulator: width 17, increment ((Baud*Oversampling)<<(16-4)+(ClkFrequency>>5))/(ClkFrequency>>4), scaled by 2^-4 relative to Oversampling=1, tick = bit 16 carry, clear bit 16 each cycle.
REQ-013 SHALL run the accumulator only outside IDLE; in IDLE it holds zero.
REQ-014 SHALL implement states IDLE, START, DATA, STOP.
REQ-015 IDLE -> START on synchronized RxD low; sample counter cleared.
REQ-016 START: at tick count Oversampling/2 SHALL go DATA if line low, else IDLE (glitch reject, no output).
REQ-017 DATA: SHALL sample line at mid-bit (every Oversampling ticks), shift LSB first, after 8th bit go STOP.
REQ-018 STOP: at mid-bit sample SHALL latch shift register into RxD_data and pulse RxD_data_ready for exactly one clk in the following cycle, then go IDLE.
REQ-019 SHALL return to IDLE at mid-stop so a start edge half a bit later is accepted (back-to-back frames).
REQ-020 RxD_data SHALL hold its value until the next valid frame.
REQ-021 SHALL count idle bit periods via the tick generator; RxD_idle rises after 10 consecutive bit times high in IDLE, falls on any low sample.
REQ-022 RxD_endofpacket SHALL pulse one clk on RxD_idle 0->1, never at reset release.

Reset
REQ-023 rst SHALL set synchronizer flops to 1, state IDLE, accumulator and counters 0, RxD_data 0x00, RxD_data_ready 0, RxD_endofpacket 0, RxD_idle 0.
REQ-024 rst mid-frame SHALL abandon the frame with no RxD_data_ready pulse.

Configuration
REQ-025 SHALL honour macro RX_FRAME_ERR_EN: when defined, adds output RxD_frame_err (1, one-clk pulse) asserted instead of RxD_data_ready when stop sample low; RxD_data unchanged; state returns IDLE only after line high.
REQ-026 Without RX_FRAME_ERR_EN no RxD_frame_err port exists and the stop bit is not checked; byte delivered regardless.

Structure
REQ-027 Shared package SHALL hold state encoding and constant DATA_BITS=8, IDLE_BITS=10.
REQ-028 Tick accumulator SHALL be sub-module baud_tick_gen (params ClkFrequency, Baud, Oversampling; ports clk, rst, enable, tick).

Verification (50 MHz, 115200, bit ~434 clk)
REQ-029 Frame 0x55, stop high -> exactly one RxD_data_ready, RxD_data=0x55.
REQ-030 RxD low 100 clk then high -> no RxD_data_ready, state IDLE.
REQ-031 0xA5 then 0x3C, one stop bit, no gap -> two pulses, values 0xA5, 0x3C in order.
REQ-032 0x81 with stop bit low -> macro on: RxD_frame_err pulse, no data_ready, RxD_data unchanged; macro off: data_ready with 0x81.
REQ-033 rst during bit 3 of 0xF0, then frame 0x0F -> outputs zero after reset, then one pulse with 0x0F.
REQ-034 Frame then 10 bit times high -> RxD_idle rises, single RxD_endofpacket pulse; next start bit drops RxD_idle.
